// File: rtl/dt_pkg.sv
// Shared definitions for the decision-tree preimage scanner.
//   DT_IN_W / DT_CLS_W : default feature-vector and class-label widths
//   scan_state_t       : scanner FSM state encoding
//   CLS_00..CLS_11     : class-label constants for 2-bit classifiers
package dt_pkg;

    localparam int DT_IN_W  = 8;
    localparam int DT_CLS_W = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        EMIT = 2'd2,
        DONE = 2'd3
    } scan_state_t;

    localparam logic [1:0] CLS_00 = 2'b00;
    localparam logic [1:0] CLS_01 = 2'b01;
    localparam logic [1:0] CLS_10 = 2'b10;
    localparam logic [1:0] CLS_11 = 2'b11;

endpackage

// File: rtl/dt_scan_ctr.sv
// Sweep index register for the preimage scanner.
//   clk, rst : clock and synchronous active-high reset
//   clr_i    : load index with zero (takes priority over inc_i)
//   inc_i    : advance index by one; ignored at the last vector so it never wraps
//   idx_o    : current index (drives the probe bus)
//   last_o   : index is all-ones, i.e. the final vector of the sweep
module dt_scan_ctr #(
    parameter int IN_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr_i,
    input  logic            inc_i,
    output logic [IN_W-1:0] idx_o,
    output logic            last_o
);

    logic [IN_W-1:0] idx_q;
    logic [IN_W-1:0] idx_d;

    // Next index: clear, increment (saturating at the last vector) or hold.
    always_comb begin
        idx_d = idx_q;
        if (clr_i) begin
            idx_d = '0;
        end else if (inc_i && !last_o) begin
            idx_d = idx_q + IN_W'(1);
        end else begin
            idx_d = idx_q;
        end
    end

    // Index register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

    assign idx_o  = idx_q;
    assign last_o = &idx_q;

endmodule

// File: rtl/dt_class_preimage_scan.sv
// Preimage scanner for a combinational decision-tree classifier: for a
// requested target class, sweeps every feature vector over the probe bus and
// streams out those the classifier maps to that class, then reports the count.
//   clk, rst            : clock, synchronous active-high reset
//   cmd_valid/cmd_ready : command handshake (ready only when idle and not in reset)
//   cmd_class           : target class
//   cmd_first_only      : stop after the first matching vector
//   abort               : cancel a running scan without a done report
//   probe_o/probe_cls_i : vector to the external classifier and its same-cycle result
//   out_valid/out_ready/out_data       : matching-vector stream
//   done_valid/done_ready/done_count   : completion report with match count
module dt_class_preimage_scan
    import dt_pkg::*;
#(
    parameter int IN_W  = DT_IN_W,
    parameter int CLS_W = DT_CLS_W,
    parameter int CNT_W = IN_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [CLS_W-1:0] cmd_class,
    input  logic             cmd_first_only,
    input  logic             abort,
    output logic [IN_W-1:0]  probe_o,
    input  logic [CLS_W-1:0] probe_cls_i,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IN_W-1:0]  out_data,
    output logic             done_valid,
    input  logic             done_ready,
    output logic [CNT_W-1:0] done_count
);

    scan_state_t      state_q;
    logic [CLS_W-1:0] target_q;
    logic             first_only_q;
    logic [CNT_W-1:0] match_cnt_q;
    logic             out_valid_q;
    logic [IN_W-1:0]  out_data_q;
    logic             done_valid_q;
    logic [CNT_W-1:0] done_count_q;

    logic [IN_W-1:0]  idx_s;
    logic             last_s;
    logic             hit_s;
    logic             ctr_clr_s;
    logic             ctr_inc_s;

    assign hit_s = (probe_cls_i == target_q);

    // Index strobes; the counter must only move on the same conditions the FSM
    // uses to step to the next vector.
    always_comb begin
        ctr_clr_s = 1'b0;
        ctr_inc_s = 1'b0;
        case (state_q)
            IDLE: begin
                ctr_clr_s = cmd_valid;
            end
            SCAN: begin
                ctr_inc_s = !abort && !hit_s && !last_s;
            end
            EMIT: begin
                ctr_inc_s = !abort && out_ready && !first_only_q && !last_s;
            end
            DONE: begin
                ctr_inc_s = 1'b0;
            end
            default: begin
                ctr_clr_s = 1'b0;
                ctr_inc_s = 1'b0;
            end
        endcase
    end

    dt_scan_ctr #(
        .IN_W (IN_W)
    ) u_ctr (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (ctr_clr_s),
        .inc_i  (ctr_inc_s),
        .idx_o  (idx_s),
        .last_o (last_s)
    );

    // Scanner FSM with registered stream and completion outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            target_q     <= '0;
            first_only_q <= 1'b0;
            match_cnt_q  <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            done_valid_q <= 1'b0;
            done_count_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    // abort has no meaning here; a concurrent command still wins
                    if (cmd_valid) begin
                        target_q     <= cmd_class;
                        first_only_q <= cmd_first_only;
                        match_cnt_q  <= '0;
                        state_q      <= SCAN;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                SCAN: begin
                    if (abort) begin
                        state_q <= IDLE;
                    end else if (hit_s) begin
                        out_data_q  <= idx_s;
                        out_valid_q <= 1'b1;
                        match_cnt_q <= match_cnt_q + CNT_W'(1);
                        state_q     <= EMIT;
                    end else if (last_s) begin
                        done_valid_q <= 1'b1;
                        done_count_q <= match_cnt_q;
                        state_q      <= DONE;
                    end else begin
                        state_q <= SCAN;
                    end
                end
                EMIT: begin
                    if (abort) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end else if (out_ready) begin
                        out_valid_q <= 1'b0;
                        if (first_only_q || last_s) begin
                            done_valid_q <= 1'b1;
                            done_count_q <= match_cnt_q;
                            state_q      <= DONE;
                        end else begin
                            state_q <= SCAN;
                        end
                    end else begin
                        state_q <= EMIT;
                    end
                end
                DONE: begin
                    if (abort) begin
                        done_valid_q <= 1'b0;
                        state_q      <= IDLE;
                    end else if (done_ready) begin
                        done_valid_q <= 1'b0;
                        state_q      <= IDLE;
                    end else begin
                        state_q <= DONE;
                    end
                end
                default: begin
                    out_valid_q  <= 1'b0;
                    done_valid_q <= 1'b0;
                    state_q      <= IDLE;
                end
            endcase
        end
    end

    assign cmd_ready  = (state_q == IDLE) && !rst;
    assign probe_o    = idx_s;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign done_valid = done_valid_q;
    assign done_count = done_count_q;

endmodule

// File: tb/tb_dt_class_preimage_scan.sv
// Self-checking bench for dt_class_preimage_scan: table-driven scans against
// stub classifiers, randomized scans against a lookup-table classifier, and
// hand-written abort / reset sequences.
module tb_dt_class_preimage_scan;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_class;
    logic       cmd_first_only;
    logic       abort;
    logic [7:0] probe_o;
    logic [1:0] probe_cls_i;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       done_valid;
    logic       done_ready;
    logic [8:0] done_count;

    int n_pass  = 0;
    int n_total = 0;

    // classifier stub: 0 = probe[1:0], 1 = const 00, 2 = const 01, 3 = random LUT
    int         cls_mode;
    logic [1:0] lut [256];
    logic [7:0] exp_q [$];

    always #5 clk = ~clk;

    dt_class_preimage_scan dut (
        .clk            (clk),
        .rst            (rst),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_class      (cmd_class),
        .cmd_first_only (cmd_first_only),
        .abort          (abort),
        .probe_o        (probe_o),
        .probe_cls_i    (probe_cls_i),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .done_valid     (done_valid),
        .done_ready     (done_ready),
        .done_count     (done_count)
    );

    function automatic logic [1:0] cls_of(input int mode, input logic [7:0] v);
        case (mode)
            0:       return v[1:0];
            1:       return 2'b00;
            2:       return 2'b01;
            default: return lut[v];
        endcase
    endfunction

    always_comb probe_cls_i = cls_of(cls_mode, probe_o);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference: all vectors whose class equals the target, in ascending order.
    task automatic build_model(input int mode, input logic [1:0] tgt, input logic fo);
        exp_q.delete();
        for (int v = 0; v < 256; v++) begin
            if (cls_of(mode, 8'(v)) == tgt) begin
                exp_q.push_back(8'(v));
                if (fo) break;
            end
        end
    endtask

    // Issue one command and follow the scan to its done report.
    // rmode: 0 = ready always, 1 = ready 1-of-3, 2 = random ready
    task automatic run_scan(input int mode, input logic [1:0] tgt, input logic fo,
                            input int rmode, input int exp_cnt, input int exp_cycles,
                            input string tag);
        int   cycles;
        int   model_cnt;
        bit   done_seen;
        bit   prev_stall;
        logic [7:0] prev_data;
        logic rdy;
        cls_mode = mode;
        build_model(mode, tgt, fo);
        model_cnt = exp_q.size();
        cmd_class      = tgt;
        cmd_first_only = fo;
        cmd_valid      = 1'b1;
        chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk({tag, "_first_probe"}, 32'(probe_o), 32'd0);
        cycles     = 0;
        done_seen  = 1'b0;
        prev_stall = 1'b0;
        prev_data  = 8'h00;
        while (!done_seen && cycles < 4000) begin
            case (rmode)
                0:       rdy = 1'b1;
                1:       rdy = (cycles % 3 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            out_ready = rdy;
            if (out_valid && rdy) begin
                if (exp_q.size() > 0) chk({tag, "_out_data"}, 32'(out_data), 32'(exp_q.pop_front()));
                else chk({tag, "_extra_out"}, 32'(out_data), 32'hFFFF_FFFF);
            end
            prev_stall = out_valid && !rdy;
            prev_data  = out_data;
            @(posedge clk); #1;
            cycles++;
            if (prev_stall) begin
                if (!(out_valid === 1'b1 && out_data === prev_data))
                    chk({tag, "_stall_hold"}, {23'd0, out_valid, out_data}, {23'd0, 1'b1, prev_data});
            end
            if (done_valid) done_seen = 1'b1;
        end
        out_ready = 1'b0;
        if (!done_seen) begin
            chk({tag, "_done_timeout"}, 32'd0, 32'd1);
        end else begin
            chk({tag, "_done_count"}, 32'(done_count), 32'((exp_cnt >= 0) ? exp_cnt : model_cnt));
            if (exp_cycles >= 0) chk({tag, "_cycles"}, 32'(cycles), 32'(exp_cycles));
            chk({tag, "_missing_out"}, 32'(exp_q.size()), 32'd0);
            @(posedge clk); #1;
            chk({tag, "_done_hold"}, 32'(done_valid), 32'd1);
            done_ready = 1'b1;
            @(posedge clk); #1;
            done_ready = 1'b0;
            chk({tag, "_done_clear"}, 32'(done_valid), 32'd0);
            chk({tag, "_back_idle"}, 32'(cmd_ready), 32'd1);
        end
    endtask

    typedef struct {
        int         mode;
        logic [1:0] tgt;
        logic       fo;
        int         rmode;
        int         exp_cnt;
        int         exp_cycles;
    } vec_t;

    vec_t vecs [4];

    initial begin
        int found;
        // mode, target, first_only, ready mode, expected count, expected cycles
        vecs[0] = '{0, 2'b10, 1'b0, 0, 64,  320};
        vecs[1] = '{0, 2'b11, 1'b1, 0, 1,   5};
        vecs[2] = '{1, 2'b01, 1'b0, 0, 0,   256};
        vecs[3] = '{2, 2'b01, 1'b0, 1, 256, -1};

        for (int i = 0; i < 256; i++) lut[i] = 2'($urandom_range(0, 3));
        cls_mode = 0;
        rst = 1'b1; cmd_valid = 1'b0; cmd_class = 2'b00; cmd_first_only = 1'b0;
        abort = 1'b0; out_ready = 1'b0; done_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_probe", 32'(probe_o), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_done_valid", 32'(done_valid), 32'd0);
        chk("rst_done_count", 32'(done_count), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 4; i++)
            run_scan(vecs[i].mode, vecs[i].tgt, vecs[i].fo, vecs[i].rmode,
                     vecs[i].exp_cnt, vecs[i].exp_cycles, $sformatf("vec%0d", i));

        for (int i = 0; i < 4; i++)
            run_scan(3, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                     int'($urandom_range(0, 2)), -1, -1, $sformatf("rnd%0d", i));

        // abort in SCAN at idx 0x40
        cls_mode = 1; cmd_class = 2'b01; cmd_first_only = 1'b0; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        found = 0;
        for (int c = 0; c < 300; c++) begin
            if (probe_o == 8'h40) begin found = 1; break; end
            @(posedge clk); #1;
        end
        chk("abort_reach_40", 32'(found), 32'd1);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_idle", 32'(cmd_ready), 32'd1);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_done_valid", 32'(done_valid), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("abort_no_done", 32'(done_valid), 32'd0);
        // abort together with a command while idle: command is accepted
        abort = 1'b1; cmd_valid = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0; cmd_valid = 1'b0;
        chk("abort_cmd_accepted", 32'(cmd_ready), 32'd0);
        chk("abort_restart_probe", 32'(probe_o), 32'd0);
        @(posedge clk); #1;
        chk("abort_restart_step", 32'(probe_o), 32'd1);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort2_idle", 32'(cmd_ready), 32'd1);

        // reset while a match is held in EMIT
        cls_mode = 0; cmd_class = 2'b10; out_ready = 1'b0; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        found = 0;
        for (int c = 0; c < 20; c++) begin
            if (out_valid) begin found = 1; break; end
            @(posedge clk); #1;
        end
        chk("emit_reached", 32'(found), 32'd1);
        chk("emit_data", 32'(out_data), 32'h02);
        @(posedge clk); #1;
        chk("emit_hold", {23'd0, out_valid, out_data}, {23'd0, 1'b1, 8'h02});
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_out_data", 32'(out_data), 32'd0);
        chk("mid_rst_probe", 32'(probe_o), 32'd0);
        chk("mid_rst_done", {23'd0, done_valid, done_count}, 32'd0);
        chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;
        chk("post_rst_idle_out", 32'(out_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
